// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - core/host request bus bundle for the register arbiter
interface reg_bus_arbiter_if;
  // core side
  logic [3:0] busreq;
  logic [3:0] instr_opnd;
  logic [3:0] wb_data;
  logic       core_ack;
  logic [3:0] rd_data;
  logic [3:0] opnd_idx;
  // host side
  logic       host_req;
  logic       host_we;
  logic [3:0] host_addr;
  logic [3:0] host_wdata;
  logic       host_gnt;
  logic [3:0] host_rdata;
  // status
  logic       busy;
  logic       err;

  // requesters (core + host) drive the request fields
  modport master (
    output busreq, instr_opnd, wb_data,
    output host_req, host_we, host_addr, host_wdata,
    input  core_ack, rd_data, opnd_idx,
    input  host_gnt, host_rdata, busy, err
  );

  // the arbiter consumes requests and returns data/handshakes
  modport slave (
    input  busreq, instr_opnd, wb_data,
    input  host_req, host_we, host_addr, host_wdata,
    output core_ack, rd_data, opnd_idx,
    output host_gnt, host_rdata, busy, err
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - 16x4 register file shared between a core and a host port
module reg_bus_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  reg_bus_arbiter_if.slave   bus
);

  localparam logic [3:0] CODE_IDLE = 4'b0000;
  localparam logic [3:0] CODE_OPND = 4'b0011;
  localparam logic [3:0] CODE_RD   = 4'b0001;
  localparam logic [3:0] CODE_WR   = 4'b0101;
  localparam logic [2:0] AGE_MAX   = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_SVC = 2'd1,
    HOST_SVC = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rf_q [16];

  logic [3:0] last_code_q;
  logic [2:0] age_q;
  logic       err_q;

  // latched winner request
  logic [3:0] code_q;
  logic [3:0] opnd_lat_q;
  logic [3:0] wbd_lat_q;
  logic       hwe_q;
  logic [3:0] haddr_q;
  logic [3:0] hwdata_q;

  // registered outputs
  logic       core_ack_q;
  logic       host_gnt_q;
  logic       busy_q;
  logic [3:0] rd_data_q;
  logic [3:0] host_rdata_q;
  logic [3:0] opnd_idx_q;

  logic core_valid;
  logic core_rsvd;
  logic core_new;
  logic host_wins;
  logic core_wins;

  // Request classification and IDLE arbitration: core has priority until
  // the host has waited long enough for its age counter to saturate.
  always_comb begin
    core_valid = (bus.busreq == CODE_OPND) || (bus.busreq == CODE_RD) ||
                 (bus.busreq == CODE_WR);
    core_rsvd  = (bus.busreq != CODE_IDLE) && !core_valid;
    core_new   = core_valid && (bus.busreq != last_code_q);
    host_wins  = bus.host_req && (!core_new || (age_q == AGE_MAX));
    core_wins  = core_new && !host_wins;
  end

  // Next-state selection; every service state lasts exactly one cycle.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (core_wins)      state_d = CORE_SVC;
        else if (host_wins) state_d = HOST_SVC;
        else                state_d = IDLE;
      end
      CORE_SVC: state_d = IDLE;
      HOST_SVC: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM, register file, request latches and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < 16; i++) rf_q[i] <= 4'd0;
      last_code_q  <= CODE_IDLE;
      age_q        <= 3'd0;
      err_q        <= 1'b0;
      code_q       <= CODE_IDLE;
      opnd_lat_q   <= 4'd0;
      wbd_lat_q    <= 4'd0;
      hwe_q        <= 1'b0;
      haddr_q      <= 4'd0;
      hwdata_q     <= 4'd0;
      core_ack_q   <= 1'b0;
      host_gnt_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_data_q    <= 4'd0;
      host_rdata_q <= 4'd0;
      opnd_idx_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      core_ack_q <= (state_d == CORE_SVC);
      host_gnt_q <= (state_d == HOST_SVC);
      busy_q     <= (state_d != IDLE);

      // host starvation age: counts waiting cycles, cleared by a grant
      if (host_gnt_q)
        age_q <= 3'd0;
      else if (bus.host_req && (age_q != AGE_MAX))
        age_q <= age_q + 3'd1;

      // a dropped request re-arms the core; a served one blocks repeats
      if (bus.busreq == CODE_IDLE)
        last_code_q <= CODE_IDLE;
      else if (state_q == CORE_SVC)
        last_code_q <= code_q;

      case (state_q)
        IDLE: begin
          if (core_rsvd) err_q <= 1'b1;
          if (core_wins) begin
            code_q     <= bus.busreq;
            opnd_lat_q <= bus.instr_opnd;
            wbd_lat_q  <= bus.wb_data;
          end else if (host_wins) begin
            hwe_q    <= bus.host_we;
            haddr_q  <= bus.host_addr;
            hwdata_q <= bus.host_wdata;
          end
        end
        CORE_SVC: begin
          case (code_q)
            CODE_OPND: opnd_idx_q       <= opnd_lat_q;
            CODE_RD:   rd_data_q        <= rf_q[opnd_idx_q];
            CODE_WR:   rf_q[opnd_idx_q] <= wbd_lat_q;
            default:   ;
          endcase
        end
        HOST_SVC: begin
          host_rdata_q <= rf_q[haddr_q];
          if (hwe_q) rf_q[haddr_q] <= hwdata_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_ack   = core_ack_q;
  assign bus.host_gnt   = host_gnt_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.opnd_idx   = opnd_idx_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed self-checking bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_bus_arbiter_if bus_if ();

  reg_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one core request: drive, observe ack in service cycle and after, release
  task automatic core_do(input logic [3:0] code, input logic [3:0] opnd,
                         input logic [3:0] wb, output logic ack1, output logic ack2);
    @(posedge clk); #1;
    bus_if.busreq     = code;
    bus_if.instr_opnd = opnd;
    bus_if.wb_data    = wb;
    @(posedge clk); #1;
    ack1 = bus_if.core_ack;
    @(posedge clk); #1;
    ack2 = bus_if.core_ack;
    bus_if.busreq = 4'b0000;
    @(posedge clk); #1;
  endtask

  // one host access: raise request, wait for grant (bounded), return read data
  task automatic host_do(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                         output logic seen, output logic [3:0] rdata);
    @(posedge clk); #1;
    bus_if.host_req   = 1'b1;
    bus_if.host_we    = we;
    bus_if.host_addr  = addr;
    bus_if.host_wdata = wdata;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_if.host_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    bus_if.host_req = 1'b0;
    @(posedge clk); #1;
    rdata = bus_if.host_rdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.busreq = 4'd0; bus_if.instr_opnd = 4'd0; bus_if.wb_data = 4'd0;
    bus_if.host_req = 1'b0; bus_if.host_we = 1'b0;
    bus_if.host_addr = 4'd0; bus_if.host_wdata = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_if.core_ack, bus_if.host_gnt, bus_if.busy, bus_if.err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {bus_if.core_ack, bus_if.host_gnt, bus_if.busy, bus_if.err});
    end
    total++;
    if ({bus_if.rd_data, bus_if.host_rdata, bus_if.opnd_idx} !== 12'h000) begin
      bad++;
      $display("FAIL reset_data got=%h want=000",
               {bus_if.rd_data, bus_if.host_rdata, bus_if.opnd_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_core_write_read;
    logic a1, a2;
    core_do(4'b0011, 4'b0001, 4'b0000, a1, a2);
    total++;
    if ({a1, a2} !== 2'b10) begin
      bad++; $display("FAIL core_opnd_ack got=%b want=10", {a1, a2});
    end
    total++;
    if (bus_if.opnd_idx !== 4'd1) begin
      bad++; $display("FAIL core_opnd_idx got=%h want=1", bus_if.opnd_idx);
    end
    core_do(4'b0101, 4'b0000, 4'b0100, a1, a2);
    total++;
    if ({a1, a2} !== 2'b10) begin
      bad++; $display("FAIL core_write_ack got=%b want=10", {a1, a2});
    end
    core_do(4'b0001, 4'b0000, 4'b0000, a1, a2);
    total++;
    if ({a1, a2} !== 2'b10) begin
      bad++; $display("FAIL core_read_ack got=%b want=10", {a1, a2});
    end
    total++;
    if (bus_if.rd_data !== 4'b0100) begin
      bad++; $display("FAIL core_read_data got=%h want=4", bus_if.rd_data);
    end
  endtask

  task automatic test_host_access;
    logic       seen;
    logic [3:0] rd;
    logic [3:0] want [4];
    logic       we_v [4];
    logic [3:0] wd_v [4];
    we_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    wd_v = '{4'd5, 4'd0, 4'd9, 4'd0};
    want = '{4'd0, 4'd5, 4'd5, 4'd9};
    for (int i = 0; i < 4; i++) begin
      host_do(we_v[i], 4'd3, wd_v[i], seen, rd);
      total++;
      if (!seen) begin
        bad++; $display("FAIL host_gnt_%0d got=0 want=1", i);
      end
      total++;
      if (rd !== want[i]) begin
        bad++; $display("FAIL host_rdata_%0d got=%h want=%h", i, rd, want[i]);
      end
    end
  endtask

  task automatic test_held_request;
    int acks;
    @(posedge clk); #1;
    bus_if.busreq = 4'b0001;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.core_ack) acks++;
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL held_single_ack got=%0d want=1", acks);
    end
    bus_if.busreq = 4'b0000;
    @(posedge clk); #1;
    bus_if.busreq = 4'b0001;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus_if.core_ack) acks++;
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL held_reissue_ack got=%0d want=1", acks);
    end
    bus_if.busreq = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reserved;
    int acks;
    int busy_cnt;
    @(posedge clk); #1;
    bus_if.busreq = 4'b1111;
    acks = 0; busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus_if.core_ack) acks++;
      if (bus_if.busy) busy_cnt++;
    end
    total++;
    if (acks != 0 || busy_cnt != 0) begin
      bad++; $display("FAIL reserved_no_service acks=%0d busy=%0d want=0/0", acks, busy_cnt);
    end
    total++;
    if (bus_if.err !== 1'b1) begin
      bad++; $display("FAIL reserved_err got=%b want=1", bus_if.err);
    end
    bus_if.busreq = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    int gnt_at;
    int clash;
    @(posedge clk); #1;
    bus_if.instr_opnd = 4'd1;
    bus_if.busreq     = 4'b0011;
    bus_if.host_we    = 1'b0;
    bus_if.host_addr  = 4'd3;
    @(posedge clk); #1;
    // core now in service; host raises its request here
    bus_if.host_req = 1'b1;
    gnt_at = 0; clash = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (bus_if.core_ack && bus_if.host_gnt) clash++;
      if (bus_if.host_gnt && gnt_at == 0) begin
        gnt_at = cyc;
        bus_if.host_req = 1'b0;
      end
      if (cyc % 2 == 1)
        bus_if.busreq = (bus_if.busreq == 4'b0011) ? 4'b0001 : 4'b0011;
    end
    bus_if.host_req = 1'b0;
    bus_if.busreq = 4'b0000;
    @(posedge clk); #1;
    total++;
    if (gnt_at < 1 || gnt_at > 8) begin
      bad++; $display("FAIL contention_gnt_latency got=%0d want=1..8", gnt_at);
    end
    total++;
    if (clash != 0) begin
      bad++; $display("FAIL contention_overlap got=%0d want=0", clash);
    end
    total++;
    if (bus_if.err !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b want=1", bus_if.err);
    end
  endtask

  task automatic test_reset_abort;
    logic       a1, a2, seen;
    logic [3:0] rd;
    core_do(4'b0011, 4'd2, 4'd0, a1, a2);
    @(posedge clk); #1;
    bus_if.busreq  = 4'b0101;
    bus_if.wb_data = 4'b0111;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_if.core_ack, bus_if.busy} !== 2'b00) begin
      bad++; $display("FAIL abort_no_ack got=%b want=00", {bus_if.core_ack, bus_if.busy});
    end
    bus_if.busreq = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_if.err !== 1'b0) begin
      bad++; $display("FAIL abort_err_clear got=%b want=0", bus_if.err);
    end
    host_do(1'b0, 4'd2, 4'd0, seen, rd);
    total++;
    if (!seen || rd !== 4'd0) begin
      bad++; $display("FAIL abort_reg_value gnt=%b got=%h want=0", seen, rd);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_core_write_read;
    test_host_access;
    test_held_request;
    test_reserved;
    test_contention;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset; asynchronous, active-low.
REQ-003: busreq  input  4  core bus request code: 0000 idle, 0011 next operand, 0001 read register, 0101 write register; all other codes reserved.
REQ-004: instr_opnd  input  4  operand field (register index) from the instruction bus.
REQ-005: wb_data  input  4  core write-back data.
REQ-006: core_ack  output  1  one-cycle pulse marking completion of a core request.
REQ-007: rd_data  output  4  register value returned to the core.
REQ-008: opnd_idx  output  4  latched operand register index.
REQ-009: host_req  input  1  host access request; level, held until host_gnt.
REQ-010: host_we  input  1  host access type: 1 write, 0 read.
REQ-011: host_addr  input  4  host register index.
REQ-012: host_wdata  input  4  host write data.
REQ-013: host_gnt  output  1  one-cycle pulse marking completion of a host access.
REQ-014: host_rdata  output  4  register value read by the host (pre-write value on writes).
REQ-015: busy  output  1  high while a request is in service.
REQ-016: err  output  1  sticky flag, set on reserved busreq code.

Function
REQ-017: The block SHALL hold a 16 x 4-bit register file, all entries writable.
REQ-018: FSM states SHALL be IDLE, CORE_SVC, HOST_SVC; busy = 1 exactly in CORE_SVC and HOST_SVC.
REQ-019: A core request SHALL be "new" when busreq != 0000 and busreq != last_code; last_code updates to the served code on core_ack and clears to 0000 whenever busreq = 0000 is sampled.
REQ-020: In IDLE, arbitration: if new core request and host_req, core wins unless host age = 7, then host wins; otherwise the single requester wins; winner's inputs latched, FSM moves to matching SVC state.
REQ-021: Host age counter (3-bit) SHALL increment each cycle host_req = 1 and host_gnt = 0, saturate at 7, clear on host_gnt.
REQ-022: CORE_SVC, code 0011: opnd_idx <= latched instr_opnd; 0001: rd_data <= rf[opnd_idx]; 0101: rf[opnd_idx] <= latched wb_data; core_ack = 1 for that one cycle; next state IDLE.
REQ-023: HOST_SVC: host_rdata <= rf[latched host_addr]; if host_we, rf[host_addr] <= latched host_wdata; host_gnt = 1 for that one cycle; next state IDLE.
REQ-024: Latency: request sampled in IDLE at edge N, ack/gnt high during cycle N+1, outputs updated at edge N+1; throughput one request per 2 cycles.
REQ-025: A reserved busreq code sampled in IDLE SHALL set err, is never acked, and does not change state or last_code.
REQ-026: core_ack and host_gnt SHALL never be high in the same cycle.
REQ-027: Held request already served (busreq = last_code) SHALL not be re-serviced.
REQ-028: rd_data, host_rdata, opnd_idx SHALL hold their value until next corresponding service.

Reset
REQ-029: rst_n low SHALL immediately force IDLE, rf all 0000, rd_data, host_rdata, opnd_idx = 0000, last_code = 0000, age = 0, core_ack = host_gnt = busy = err = 0.
REQ-030: Reset asserted during CORE_SVC or HOST_SVC SHALL abort the access: no ack/gnt pulse, no register write.
REQ-031: err SHALL clear only via reset.

Verification
REQ-032: Core write then read: busreq 0011 instr_opnd 0001 -> opnd_idx = 1, ack; busreq 0101 wb_data 0100 -> ack; busreq 0001 -> rd_data = 0100, core_ack pulse 1 cycle after sampling.
REQ-033: Host write 5 to reg 3, host read reg 3 -> host_rdata = 0101; write of 9 over it -> host_rdata = 0101 (old value), next read -> 1001.
REQ-034: Contention: core busreq toggling new codes every 2 cycles with host_req held -> host_gnt within 8 cycles of host_req rise, never concurrent with core_ack.
REQ-035: Busreq held at 0001 for 10 cycles -> exactly one core_ack; drop to 0000 then 0001 again -> second ack.
REQ-036: busreq = 1111 -> err = 1, no ack, err stays 1 until rst_n low.
REQ-037: rst_n pulsed low in CORE_SVC of a 0101 write of 0111 -> no ack, target register reads 0000 afterward.
